digit_serial_addsub: RTL
========================

Name: digit_serial_addsub

Overview:
- Sequential 2's-complement adder/subtractor that reuses one 2-bit slice over N/2 clock cycles, LSB digit first.
- Time-iterated counterpart to the team's space-iterated ripple N-bit adder.
- Used where area matters more than latency, and where subtraction with borrow is required.
- Operands are captured on a start handshake; results are presented with a one-cycle done pulse.

Parameters:
- N, 8, operand/result width in bits; must be even and >=2 (elaboration-time assertion).
- NUM_DIGITS, N/2, derived localparam; number of 2-bit iterations.

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- op  input  1  0 = add (a+b+ci), 1 = subtract (a-b-ci)
- a  input  N  operand A, captured when start is accepted
- b  input  N  operand B, captured when start is accepted
- ci  input  1  carry-in (add) or borrow-in (sub), captured with operands
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, high in the DONE state
- s  output  N  result, registered
- co  output  1  add: carry-out of bit N-1; sub: borrow-out (1 when a < b+ci, unsigned)
- ovf  output  1  signed overflow: carry into bit N-1 XOR carry out of bit N-1

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, busy=0, done=0, s=0, co=0, ovf=0, digit counter=0, all internal operand/carry registers=0. Reset has priority over everything, including mid-RUN; no done is produced for an aborted operation.
- States: IDLE, RUN, DONE.
- IDLE & start: capture a, b' = op ? ~b : b, carry = op ? ~ci : ci, k=0; go to RUN. IDLE & !start: stay.
- RUN, each cycle: the slice computes {c_out, sum[1:0]} = a[2k+1:2k] + b'[2k+1:2k] + carry. Write sum into the work register bits [2k+1:2k]; carry <= c_out; k <= k+1.
- On the last digit (k = NUM_DIGITS-1):
  - latch the internal carry into bit 2k+1 as c_msb_in;
  - go to DONE;
  - on the same edge, load s <= completed work value, co <= op ? ~c_out : c_out, ovf <= c_msb_in ^ c_out.
- start during RUN is ignored (not queued).
- DONE: done=1, busy=0 for exactly one cycle. Next edge: start=1 goes to RUN with new operands (back-to-back); otherwise go to IDLE.
- Latency: start accepted at edge t → busy=1 after t → DONE entered at edge t+NUM_DIGITS → done is high and sampled at edge t+NUM_DIGITS+1.
- Throughput: one operation per NUM_DIGITS+1 cycles.
- s, co and ovf change only on entry to DONE, and hold until the next completion or reset. They do not toggle during RUN.
- Inputs a, b, op and ci may change freely after start is accepted without affecting the result.
- Wrap-around: carry/borrow out of bit N-1 is reported only via co. s is the low N bits, modulo 2^N.

Decomposition:
- Package addsub_pkg: state enum {IDLE, RUN, DONE}; constants OP_ADD=1'b0 and OP_SUB=1'b1; digit-width constant DIGIT_W=2.
- Sub-module addsub_digit_slice (combinational):
  - inputs: 2-bit x, 2-bit y, cin;
  - outputs: 2-bit sum, c_mid (carry into the upper bit), cout.
  - Instantiated once. The FSM, counter and registers live in digit_serial_addsub.

Test Plan:
- N=8, add, a=8'h5A, b=8'h3C, ci=0 → s=8'h96, co=0, ovf=1; done high exactly 5 cycles after the start edge, busy high for 4 cycles.
- N=8, add, a=8'hFF, b=8'h01, ci=1 → s=8'h01, co=1, ovf=0.
- N=8, sub, a=8'h0A, b=8'h14, ci=0 → s=8'hF6, co=1 (borrow), ovf=0. Then sub, a=8'h80, b=8'h01, ci=0 → s=8'h7F, co=0, ovf=1.
- start re-pulsed during RUN, with a/b changed mid-RUN → ignored; result matches the originally captured operands. start held high through the DONE cycle → second operation starts immediately, second done 5 cycles after the first.
- rst=1 asserted on the 2nd RUN cycle → next cycle state=IDLE, busy=0, s=0, co=0, ovf=0; no done pulse. A subsequent start completes normally.
- Randomized sweep of 1000 ops, N=8 and N=4, both op values and random ci → s, co and ovf match a reference-model computation.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state encoding, operation codes, digit width.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bits consumed per clock by the arithmetic slice.
    localparam int DIGIT_W = 2;

endpackage

// File: rtl/digit_serial_addsub_if.sv
// Request/result bundle between a requester and digit_serial_addsub.
// Latency: n/a (wires only).
// Backpressure: none; start is sampled only when the engine is idle or done.
//
// Ports:
//   start, op, a, b, ci : requester -> engine (operands captured on accept)
//   busy, done, s, co, ovf : engine -> requester (done is a one-cycle pulse)
interface digit_serial_addsub_if #(
    parameter int N = 8
);
    logic         start;
    logic         op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [N-1:0] s;
    logic         co;
    logic         ovf;

    modport master (
        output start, op, a, b, ci,
        input  busy, done, s, co, ovf
    );

    modport slave (
        input  start, op, a, b, ci,
        output busy, done, s, co, ovf
    );
endinterface

// File: rtl/addsub_digit_slice.sv
// Two-bit ripple adder slice, purely combinational.
// Latency: 0 cycles.
// Backpressure: none.
//
// Ports:
//   x, y  : 2-bit operand digits
//   cin   : carry into bit 0 of the digit
//   sum   : 2-bit digit sum
//   c_mid : carry into bit 1 of the digit (needed for signed overflow on the top digit)
//   cout  : carry out of bit 1 of the digit
module addsub_digit_slice
    import addsub_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               c_mid,
    output logic               cout
);

    always_comb begin
        sum[0] = x[0] ^ y[0] ^ cin;
        c_mid  = (x[0] & y[0]) | (cin & (x[0] ^ y[0]));
        sum[1] = x[1] ^ y[1] ^ c_mid;
        cout   = (x[1] & y[1]) | (c_mid & (x[1] ^ y[1]));
    end

endmodule

// File: rtl/digit_serial_addsub.sv
// Two's-complement add/subtract of N-bit operands, two bits per clock, LSB digit first.
// Latency: start accepted at edge t -> done high for the cycle after edge t+N/2.
// Backpressure: none; start is ignored while busy, one op per N/2+1 cycles.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, aborts any operation without a done pulse
//   bus  : request/result bundle (slave side), see digit_serial_addsub_if
module digit_serial_addsub
    import addsub_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    digit_serial_addsub_if.slave   bus
);

    localparam int NUM_DIGITS = N / 2;
    localparam int KW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    generate
        if ((N < 2) || ((N % 2) != 0)) begin : g_bad_width
            $error("digit_serial_addsub: N must be even and >= 2");
        end
    endgenerate

    state_t        state;
    logic [KW-1:0] k;
    // Operand registers shift right one digit per RUN cycle so the slice
    // always sees the current digit in bits [1:0].
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    // Result digits enter at the top and shift down; after NUM_DIGITS
    // cycles every digit sits at its final position.
    logic [N-1:0]  work;
    logic [N-1:0]  work_nxt;
    logic          carry;
    logic          op_r;

    logic          busy_r;
    logic          done_r;
    logic [N-1:0]  s_r;
    logic          co_r;
    logic          ovf_r;

    logic [DIGIT_W-1:0] dsum;
    logic               c_mid;
    logic               c_out;
    logic               last;

    addsub_digit_slice u_slice (
        .x     (a_r[DIGIT_W-1:0]),
        .y     (b_r[DIGIT_W-1:0]),
        .cin   (carry),
        .sum   (dsum),
        .c_mid (c_mid),
        .cout  (c_out)
    );

    always_comb begin
        work_nxt = work >> DIGIT_W;
        work_nxt[N-1 -: DIGIT_W] = dsum;
    end

    assign last = (k == KW'(NUM_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            a_r    <= '0;
            b_r    <= '0;
            work   <= '0;
            carry  <= 1'b0;
            op_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            s_r    <= '0;
            co_r   <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        // Subtract as a + ~b + ~ci, which equals a - b - ci.
                        a_r    <= bus.a;
                        b_r    <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
                        carry  <= (bus.op == OP_SUB) ? ~bus.ci : bus.ci;
                        op_r   <= bus.op;
                        k      <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end

                RUN: begin
                    a_r   <= a_r >> DIGIT_W;
                    b_r   <= b_r >> DIGIT_W;
                    work  <= work_nxt;
                    carry <= c_out;
                    k     <= k + 1'b1;
                    if (last) begin
                        // c_mid on the top digit is the carry into bit N-1.
                        s_r    <= work_nxt;
                        co_r   <= (op_r == OP_SUB) ? ~c_out : c_out;
                        ovf_r  <= c_mid ^ c_out;
                        k      <= '0;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end

                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.s    = s_r;
    assign bus.co   = co_r;
    assign bus.ovf  = ovf_r;

endmodule
